pio_poll_master: RTL

Avalon-MM host that periodically reads the data register of a read-only input PIO slave, keeps the latest sample, and flags changes. It sits between a PIO input peripheral and fabric logic that needs pin state without Nios software polling. It is the initiator end of the PIO's `s1` slave port: it issues reads on `address` 0 and consumes the 32-bit `readdata`.

---
 rtl/pio_poll_master.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pio_poll_master.sv
// pio_poll_master: Avalon-MM host polling a read-only PIO data register.
// Optional rising-edge capture enabled by PIO_POLL_MASTER_EDGE_CAPTURE_EN.
module pio_poll_master #(
   parameter int WIDTH        = 1,
   parameter int POLL_PERIOD  = 1000,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [1:0]       avm_address,
   output logic             avm_read,
   input  logic             avm_waitrequest,
   input  logic [31:0]      avm_readdata,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid,
   output logic             change_pulse,
   output logic             timeout_err,
   input  logic             err_clear,
   output logic [WIDTH-1:0] edge_capture,
   input  logic             edge_clear
);

   localparam int CW = $clog2(POLL_PERIOD + 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAIT_DATA
   } state_t;

   state_t           state, state_d;
   logic [CW-1:0]    per_cnt;
   logic             tick;
   logic             pending, pending_d;
   logic [2:0]       lat_cnt, lat_d;
   logic [15:0]      stall_cnt, stall_d;
   logic             capture;
   logic             abort;
   logic [WIDTH-1:0] new_val;
   logic             unused;

   assign avm_address = 2'd0;
   assign avm_read    = (state == READ);
   assign tick        = enable && (per_cnt == CW'(POLL_PERIOD - 1));
   assign new_val     = avm_readdata[WIDTH-1:0];
   assign unused      = ^{edge_clear, avm_readdata};

   // Free-running poll period counter, parked at 0 while disabled
   always_ff @(posedge clk) begin
      if (reset) begin
         per_cnt <= '0;
      end else if (!enable || tick) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + 1'b1;
      end
   end

   // Transaction FSM: next state, pending collapse, latency and stall counts
   always_comb begin
      state_d   = state;
      pending_d = pending;
      lat_d     = lat_cnt;
      stall_d   = stall_cnt;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            stall_d = '0;
            if (tick || pending) begin
               state_d   = READ;
               pending_d = 1'b0;
            end
         end
         READ: begin
            if (tick) pending_d = 1'b1;
            if (!avm_waitrequest) begin
               state_d = WAIT_DATA;
               lat_d   = 3'(READ_LATENCY);
            end else if (stall_cnt == 16'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_d = IDLE;
            end else begin
               stall_d = stall_cnt + 16'd1;
            end
         end
         WAIT_DATA: begin
            if (tick) pending_d = 1'b1;
            if (lat_cnt == 3'd1) begin
               capture = 1'b1;
               state_d = IDLE;
            end else begin
               lat_d = lat_cnt - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) pending_d = 1'b0;
   end

   // FSM state and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pending   <= 1'b0;
         lat_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_d;
         pending   <= pending_d;
         lat_cnt   <= lat_d;
         stall_cnt <= stall_d;
      end
   end

   // Sample capture, change detection and sticky timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         change_pulse <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         change_pulse <= capture && sample_valid && (new_val != sample);
         if (capture) begin
            sample       <= new_val;
            sample_valid <= 1'b1;
         end
         if (abort) begin
            timeout_err <= 1'b1;
         end else if (err_clear) begin
            timeout_err <= 1'b0;
         end
      end
   end

`ifdef PIO_POLL_MASTER_EDGE_CAPTURE_EN
   // Sticky rising-edge bits; a new rise beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_capture <= '0;
      end else if (capture && sample_valid) begin
         edge_capture <= (edge_clear ? '0 : edge_capture) | (new_val & ~sample);
      end else if (edge_clear) begin
         edge_capture <= '0;
      end
   end
`else
   assign edge_capture = '0;
`endif

endmodule
